alu_issue_queue: RTL
====================

Name: alu_issue_queue

Overview:
- Age-ordered issue queue for the ALU pipe; sits between rename/dispatch and the ALU execute stage.
- Holds dispatched ALU ops until both source operands are available, either captured at dispatch or woken by the bypass buses.
- Selects the oldest ready entry each cycle and drives issue_to_alu_valid plus a fully populated issue_to_execute_bus_t carrying operand values.

Parameters:
- DEPTH, 8, number of queue entries (power of two not required).
- NUM_BYPASS, 3, number of bypass_bus_t inputs snooped for wakeup.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- flush  input  1  pipeline flush; empties the queue.
- dispatch_valid  input  1  dispatch presents a new ALU op.
- iq_allowin  output  1  queue can accept a dispatch this cycle.
- dispatch_inst  input  iq_dispatch_bus_t  op, phy_dest, rob_entry_num, and per source {phy, ready, value}.
- bypass_bus  input  NUM_BYPASS x bypass_bus_t  {we[3:0], phy_dest, result} from the execute units.
- issue_to_alu_valid  output  1  an entry issues this cycle.
- issue_inst  output  issue_to_execute_bus_t  inst, phy_dest, src1_value, src2_value, rob_entry_num.

Behaviour:
- Reset (async, resetn=0): all entries invalid, count=0, iq_allowin=1, issue_to_alu_valid=0, issue_inst=0.
- Storage is a compacting shift queue. Entry 0 is the oldest. Entry fields: valid, inst, phy_dest, rob_entry_num, and for each source: phy, rdy, value.
- iq_allowin = (count < DEPTH).
  - It depends only on registered count, never on the current cycle's issue (no comb loop).
  - Dispatch is accepted when dispatch_valid && iq_allowin && !flush.
- Wakeup: for every valid entry and every source with rdy=0, bypass k matches if bypass_bus[k].we[0]=1 and bypass_bus[k].phy_dest == src.phy.
  - On a match, the entry latches rdy=1 and value=result at the clock edge.
  - If several buses match, the lowest k wins (buses must not legally both write one tag).
  - phy 0 is never matched; dispatch marks $zero sources ready with value 0.
- Dispatch-cycle capture: the same match logic is applied to the incoming dispatch sources, so a producer broadcasting in the dispatch cycle is not missed.
- Ready = valid && src1.rdy && src2.rdy, evaluated on registered state. A source woken at edge N can issue in cycle N+1 (1-cycle wakeup-to-issue).
- Select: lowest-index ready entry (oldest-first).
  - issue_to_alu_valid and issue_inst are combinational from that entry.
  - issue_inst fields are 0 when nothing issues.
  - There is no downstream backpressure: the ALU always accepts.
- Update at the clock edge:
  - The issued entry is removed and entries above it shift down by one (carrying any wakeup captured this cycle).
  - An accepted dispatch is written at position count (or count-1 if an issue happened the same cycle).
  - count' = count + accept - issue.
- Simultaneous dispatch and issue when count=DEPTH: dispatch is not accepted (allowin=0); the issue proceeds and count becomes DEPTH-1.
- flush:
  - Forces issue_to_alu_valid=0 in the same cycle.
  - Next edge: all valid=0 and count=0.
  - Dispatch and wakeup in that cycle are discarded.
- Empty queue: issue_to_alu_valid=0. A dispatched op that is fully ready issues no earlier than the cycle after dispatch.

Decomposition:
- Shared cpu package: iq_dispatch_bus_t, iq_entry_t and iq_src_t typedefs, reuse of reg_addr_t/uint32_t/decoded_inst_t/bypass_bus_t, and the ZERO_PHY constant.
- One sub-module: iq_wakeup_match. It takes one source tag plus all bypass buses and returns {hit, value}. It is instantiated per entry per source and for the two dispatch sources.

Test Plan:
- Reset then dispatch an op with both sources ready (values 5, 7) -> issue_to_alu_valid=1 the next cycle, src1_value=5, src2_value=7; queue then empty.
- Dispatch A (src1 phy 12 not ready) then B (ready) -> B issues first. Bypass {we=4'hF, phy 12, 32'hDEAD_BEEF} -> A issues the following cycle with src1_value=32'hDEAD_BEEF.
- Dispatch with src2 phy 9 not ready while bypass broadcasts phy 9 = 32'h1234 the same cycle -> entry captured ready; issues the next cycle with src2_value=32'h1234.
- Fill 8 non-ready entries -> iq_allowin=0, dispatch_valid ignored. Wake entry 3 -> it issues, entries 4..7 shift down, count=7, iq_allowin=1.
- Three entries ready simultaneously at indices 0,1,2 -> issues in rob_entry_num dispatch order across 3 consecutive cycles.
- Assert flush with 5 entries (one ready) -> issue_to_alu_valid=0 in the flush cycle; the next cycle count=0 and nothing issues. Drop resetn asynchronously mid-operation -> outputs go to 0 immediately.

Source files
------------

// File: rtl/alu_issue_queue_pkg.sv
// Shared types for the ALU issue queue: dispatch/issue payloads, queue entries and bypass buses.
package alu_issue_queue_pkg;

  localparam int unsigned PHY_W  = 6;
  localparam int unsigned ROB_W  = 6;
  localparam int unsigned INST_W = 8;
  localparam int unsigned XLEN   = 32;

  typedef logic [PHY_W-1:0]  reg_addr_t;
  typedef logic [XLEN-1:0]   uint32_t;
  typedef logic [INST_W-1:0] decoded_inst_t;
  typedef logic [ROB_W-1:0]  rob_idx_t;

  localparam reg_addr_t ZERO_PHY = '0;

  typedef struct packed {
    logic [3:0] we;
    reg_addr_t  phy_dest;
    uint32_t    result;
  } bypass_bus_t;

  typedef struct packed {
    reg_addr_t phy;
    logic      rdy;
    uint32_t   value;
  } iq_src_t;

  typedef struct packed {
    decoded_inst_t inst;
    reg_addr_t     phy_dest;
    rob_idx_t      rob_entry_num;
    iq_src_t       src1;
    iq_src_t       src2;
  } iq_dispatch_bus_t;

  typedef struct packed {
    logic          valid;
    decoded_inst_t inst;
    reg_addr_t     phy_dest;
    rob_idx_t      rob_entry_num;
    iq_src_t       src1;
    iq_src_t       src2;
  } iq_entry_t;

  typedef struct packed {
    decoded_inst_t inst;
    reg_addr_t     phy_dest;
    uint32_t       src1_value;
    uint32_t       src2_value;
    rob_idx_t      rob_entry_num;
  } issue_to_execute_bus_t;

  function automatic logic entry_ready(iq_entry_t e);
    return e.valid && e.src1.rdy && e.src2.rdy;
  endfunction

endpackage

// File: rtl/alu_issue_queue_wakeup_match.sv
// Compares one source tag against every bypass bus; the lowest-numbered matching bus supplies the value.
module iq_wakeup_match
  import alu_issue_queue_pkg::*;
#(
  parameter int unsigned NUM_BYPASS = 3
) (
  input  reg_addr_t   tag_i,
  input  bypass_bus_t bypass_i [NUM_BYPASS],
  output logic        hit_o,
  output uint32_t     value_o
);

  logic [3*NUM_BYPASS-1:0] unused_we;

  for (genvar k = 0; k < int'(NUM_BYPASS); k++) begin : g_unused
    assign unused_we[3*k +: 3] = bypass_i[k].we[3:1];
  end

  // Scan from the highest bus down so the lowest matching bus is the last writer.
  always_comb begin
    hit_o   = 1'b0;
    value_o = '0;
    for (int k = int'(NUM_BYPASS) - 1; k >= 0; k--) begin
      if (bypass_i[k].we[0] && (bypass_i[k].phy_dest == tag_i) && (tag_i != ZERO_PHY)) begin
        hit_o   = 1'b1;
        value_o = bypass_i[k].result;
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Age-ordered compacting issue queue for the ALU pipe: bypass wakeup, oldest-ready select, shift-down removal.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned NUM_BYPASS = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  dispatch_valid,
  output logic                  iq_allowin,
  input  iq_dispatch_bus_t      dispatch_inst,
  input  bypass_bus_t           bypass_bus [NUM_BYPASS],
  output logic                  issue_to_alu_valid,
  output issue_to_execute_bus_t issue_inst
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  iq_entry_t        entries_q [DEPTH];
  iq_entry_t        entries_d [DEPTH];
  iq_entry_t        woken     [DEPTH+1];
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0] s1_hit, s2_hit;
  uint32_t          s1_val [DEPTH];
  uint32_t          s2_val [DEPTH];
  logic             d1_hit, d2_hit;
  uint32_t          d1_val, d2_val;

  logic             issue_any, issue_fire, accept;
  logic [IDX_W-1:0] issue_idx;
  logic [CNT_W-1:0] wr_idx;
  iq_entry_t        new_entry;

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_entry
    iq_wakeup_match #(.NUM_BYPASS(NUM_BYPASS)) u_src1 (
      .tag_i(entries_q[i].src1.phy), .bypass_i(bypass_bus), .hit_o(s1_hit[i]), .value_o(s1_val[i])
    );
    iq_wakeup_match #(.NUM_BYPASS(NUM_BYPASS)) u_src2 (
      .tag_i(entries_q[i].src2.phy), .bypass_i(bypass_bus), .hit_o(s2_hit[i]), .value_o(s2_val[i])
    );
  end

  iq_wakeup_match #(.NUM_BYPASS(NUM_BYPASS)) u_disp_src1 (
    .tag_i(dispatch_inst.src1.phy), .bypass_i(bypass_bus), .hit_o(d1_hit), .value_o(d1_val)
  );
  iq_wakeup_match #(.NUM_BYPASS(NUM_BYPASS)) u_disp_src2 (
    .tag_i(dispatch_inst.src2.phy), .bypass_i(bypass_bus), .hit_o(d2_hit), .value_o(d2_val)
  );

  function automatic iq_src_t capture_src(iq_src_t s, logic hit, uint32_t val);
    iq_src_t r;
    r = s;
    if (s.phy == ZERO_PHY) begin
      r.rdy   = 1'b1;
      r.value = '0;
    end else if (!s.rdy && hit) begin
      r.rdy   = 1'b1;
      r.value = val;
    end
    return r;
  endfunction

  // Entries as they will look after this cycle's wakeups; the extra top slot feeds the shift.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      woken[i] = entries_q[i];
      if (entries_q[i].valid && !entries_q[i].src1.rdy && s1_hit[i]) begin
        woken[i].src1.rdy   = 1'b1;
        woken[i].src1.value = s1_val[i];
      end
      if (entries_q[i].valid && !entries_q[i].src2.rdy && s2_hit[i]) begin
        woken[i].src2.rdy   = 1'b1;
        woken[i].src2.value = s2_val[i];
      end
    end
    woken[DEPTH] = '0;
  end

  always_comb begin
    issue_any = 1'b0;
    issue_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (entry_ready(entries_q[i])) begin
        issue_any = 1'b1;
        issue_idx = IDX_W'(i);
      end
    end
  end

  assign issue_fire         = issue_any && !flush;
  assign issue_to_alu_valid = issue_fire;
  assign iq_allowin         = (count_q < CNT_W'(DEPTH));
  assign accept             = dispatch_valid && iq_allowin && !flush;
  assign wr_idx             = count_q - CNT_W'(issue_fire);

  always_comb begin
    issue_inst = '0;
    if (issue_fire) begin
      issue_inst.inst          = entries_q[issue_idx].inst;
      issue_inst.phy_dest      = entries_q[issue_idx].phy_dest;
      issue_inst.src1_value    = entries_q[issue_idx].src1.value;
      issue_inst.src2_value    = entries_q[issue_idx].src2.value;
      issue_inst.rob_entry_num = entries_q[issue_idx].rob_entry_num;
    end
  end

  always_comb begin
    new_entry               = '0;
    new_entry.valid         = 1'b1;
    new_entry.inst          = dispatch_inst.inst;
    new_entry.phy_dest      = dispatch_inst.phy_dest;
    new_entry.rob_entry_num = dispatch_inst.rob_entry_num;
    new_entry.src1          = capture_src(dispatch_inst.src1, d1_hit, d1_val);
    new_entry.src2          = capture_src(dispatch_inst.src2, d2_hit, d2_val);
  end

  // Remove the issued slot by shifting everything above it down, then append the dispatch.
  always_comb begin
    count_d = count_q + CNT_W'(accept) - CNT_W'(issue_fire);
    for (int i = 0; i < int'(DEPTH); i++) begin
      entries_d[i] = woken[i];
      if (issue_fire && (IDX_W'(i) >= issue_idx)) begin
        entries_d[i] = woken[i+1];
      end
      if (accept && (CNT_W'(i) == wr_idx)) begin
        entries_d[i] = new_entry;
      end
      if (flush) begin
        entries_d[i] = '0;
      end
    end
    if (flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

endmodule
